// File: rtl/tmr_pkg.sv
// Shared lane codes and monitor FSM states for the TMR vote monitor and its voter.
package tmr_pkg;

  localparam logic [1:0] LANE_A     = 2'd0;
  localparam logic [1:0] LANE_B     = 2'd1;
  localparam logic [1:0] LANE_C     = 2'd2;
  localparam logic [1:0] LANE_MULTI = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/tmr_majority.sv
// Combinational three-lane voter: bitwise majority, disagreement mask and the
// lane that is out of step (LANE_MULTI when different bits blame different lanes).
module tmr_majority
  import tmr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] voted_o,
  output logic [WIDTH-1:0] mask_o,
  output logic [1:0]       lane_o
);

  logic [WIDTH-1:0] odd_a;
  logic [WIDTH-1:0] odd_b;
  logic [WIDTH-1:0] odd_c;

  assign voted_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign mask_o  = (a_i ^ b_i) | (a_i ^ c_i);

  // With binary lanes every disagreeing bit has exactly one odd lane.
  assign odd_a = (a_i ^ b_i) & (a_i ^ c_i);
  assign odd_b = (b_i ^ a_i) & (b_i ^ c_i);
  assign odd_c = (c_i ^ a_i) & (c_i ^ b_i);

  always_comb begin
    // NOTE: assign a default first so every path drives lane_o and no latch is inferred.
    lane_o = LANE_MULTI;
    if (mask_o == '0) begin
      lane_o = LANE_A;
    end else if (odd_a == mask_o) begin
      lane_o = LANE_A;
    end else if (odd_b == mask_o) begin
      lane_o = LANE_B;
    end else if (odd_c == mask_o) begin
      lane_o = LANE_C;
    end
  end

endmodule

// File: rtl/tmr_vote_monitor.sv
// Majority voter with SEU statistics and a valid/ready event channel.
// Define TMR_VOTE_REG_EN to register voted_o (one cycle of latency).
module tmr_vote_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic             chk_en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] voted_o,
  output logic             tmr_err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [1:0]       evt_lane_o,
  output logic [WIDTH-1:0] evt_mask_o,
  output logic             evt_ovf_o
);

  logic [WIDTH-1:0] voted_c;
  logic [WIDTH-1:0] mask_c;
  logic [1:0]       lane_c;
  logic             err;
  logic             load;

  state_t           state_q, state_d;
  logic             tmr_err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lane_q, lane_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             ovf_q, ovf_d;

  tmr_majority #(.WIDTH(WIDTH)) u_majority (
    .a_i     (a_i),
    .b_i     (b_i),
    .c_i     (c_i),
    .voted_o (voted_c),
    .mask_o  (mask_c),
    .lane_o  (lane_c)
  );

  assign err = chk_en_i & (|mask_c);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    mask_d  = mask_q;
    ovf_d   = ovf_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (err) begin
          state_d = HOLD;
          load    = 1'b1;
        end
      end
      HOLD: begin
        // A handshake frees the slot, so a concurrent error reloads with no bubble.
        if (evt_ready_i) begin
          if (err) load = 1'b1;
          else     state_d = IDLE;
        end else if (err) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      lane_d = lane_c;
      mask_d = mask_c;
    end

    // Clear dominates the sticky overflow; the counter still records this cycle's error.
    if (clr_i) begin
      ovf_d = 1'b0;
      cnt_d = err ? CNT_W'(1) : '0;
    end else if (err && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      tmr_err_q <= 1'b0;
      cnt_q     <= '0;
      lane_q    <= LANE_A;
      mask_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      tmr_err_q <= err;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      mask_q    <= mask_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef TMR_VOTE_REG_EN
  logic [WIDTH-1:0] voted_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) voted_q <= '0;
    else       voted_q <= voted_c;
  end

  assign voted_o = voted_q;
`else
  assign voted_o = voted_c;
`endif

  assign tmr_err_o   = tmr_err_q;
  assign err_cnt_o   = cnt_q;
  assign evt_valid_o = (state_q == HOLD);
  assign evt_lane_o  = lane_q;
  assign evt_mask_o  = mask_q;
  assign evt_ovf_o   = ovf_q;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Self-checking bench for tmr_vote_monitor: directed scenarios plus randomized
// traffic compared against a per-bit behavioural model of voting and event logging.
module tb_tmr_vote_monitor;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic [WIDTH-1:0] a, b, c;
  logic             chk_en, clr, ready;
  logic [WIDTH-1:0] voted;
  logic             tmr_err;
  logic [CNT_W-1:0] err_cnt;
  logic             evt_valid;
  logic [1:0]       evt_lane;
  logic [WIDTH-1:0] evt_mask;
  logic             evt_ovf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       m_pend;
  int       m_lane;
  int       m_mask;
  bit       m_ovf;
  int       m_cnt;
  bit       m_terr;
  int       m_vq;

  always #5 clk = ~clk;

  tmr_vote_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .a_i         (a),
    .b_i         (b),
    .c_i         (c),
    .chk_en_i    (chk_en),
    .clr_i       (clr),
    .voted_o     (voted),
    .tmr_err_o   (tmr_err),
    .err_cnt_o   (err_cnt),
    .evt_valid_o (evt_valid),
    .evt_ready_i (ready),
    .evt_lane_o  (evt_lane),
    .evt_mask_o  (evt_mask),
    .evt_ovf_o   (evt_ovf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ref_vote(input int x, input int y, input int z);
    int r = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i] + y[i] + z[i] >= 2) r |= (1 << i);
    end
    return r;
  endfunction

  function automatic int ref_mask(input int x, input int y, input int z);
    int r = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!(x[i] == y[i] && y[i] == z[i])) r |= (1 << i);
    end
    return r;
  endfunction

  // Lane 0/1/2 when every disagreeing bit blames that lane, 3 otherwise.
  function automatic int ref_lane(input int x, input int y, input int z);
    int blamed = -1;
    int odd;
    for (int i = 0; i < WIDTH; i++) begin
      if (!(x[i] == y[i] && y[i] == z[i])) begin
        if (y[i] == z[i])      odd = 0;
        else if (x[i] == z[i]) odd = 1;
        else                   odd = 2;
        if (blamed == -1)       blamed = odd;
        else if (blamed != odd) blamed = 3;
      end
    end
    return (blamed == -1) ? 0 : blamed;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_lane = 0; m_mask = 0; m_ovf = 0; m_cnt = 0; m_terr = 0; m_vq = 0;
  endtask

  task automatic model_edge();
    int  mk   = ref_mask(a, b, c);
    bit  e    = chk_en && (mk != 0);
    bit  ld   = 0;
    if (!m_pend) begin
      if (e) begin m_pend = 1; ld = 1; end
    end else if (ready) begin
      if (e) ld = 1;
      else   m_pend = 0;
    end else if (e && !clr) begin
      m_ovf = 1;
    end
    if (ld) begin
      m_lane = ref_lane(a, b, c);
      m_mask = mk;
    end
    if (clr) begin
      m_ovf = 0;
      m_cnt = e ? 1 : 0;
    end else if (e && m_cnt < CNT_MAX) begin
      m_cnt++;
    end
    m_terr = e;
    m_vq   = ref_vote(a, b, c);
  endtask

  function automatic int exp_voted();
`ifdef TMR_VOTE_REG_EN
    return m_vq;
`else
    return ref_vote(a, b, c);
`endif
  endfunction

  task automatic check_regs();
    check("tmr_err", tmr_err, m_terr);
    check("err_cnt", err_cnt, m_cnt);
    check("evt_valid", evt_valid, m_pend);
    check("evt_ovf", evt_ovf, m_ovf);
    if (m_pend) begin
      check("evt_lane", evt_lane, m_lane);
      check("evt_mask", evt_mask, m_mask);
    end
  endtask

  // Drive one cycle of inputs, check voted before the edge, registers after it.
  task automatic do_cycle(input logic [WIDTH-1:0] ai, bi, ci,
                          input logic ce, cl, rd);
    a = ai; b = bi; c = ci; chk_en = ce; clr = cl; ready = rd;
    #1;
    check("voted", voted, exp_voted());
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    a = '0; b = '0; c = '0; chk_en = 1'b0; clr = 1'b0; ready = 1'b0;
    #2;
    model_reset();
    check("rst_voted", voted, 0);
    check("rst_tmr_err", tmr_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_lane", evt_lane, 0);
    check("rst_evt_mask", evt_mask, 0);
    check("rst_evt_ovf", evt_ovf, 0);
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] base, ra, rb, rc;
    int kind;

    apply_reset();
    @(posedge clk); #1;

    // Agreeing lanes: quiet monitor
    for (int i = 0; i < 10; i++) do_cycle(8'h5A, 8'h5A, 8'h5A, 1, 0, 0);
    check("quiet_cnt", err_cnt, 0);

    // Single upset on lane A
    a = 8'h5B; b = 8'h5A; c = 8'h5A; chk_en = 1; clr = 0; ready = 0;
    #1;
`ifndef TMR_VOTE_REG_EN
    check("upsetA_voted", voted, 8'h5A);
`endif
    @(posedge clk); model_edge(); #1; check_regs();
    check("upsetA_terr", tmr_err, 1);
    check("upsetA_valid", evt_valid, 1);
    check("upsetA_lane", evt_lane, 0);
    check("upsetA_mask", evt_mask, 8'h01);
    check("upsetA_cnt", err_cnt, 1);
`ifdef TMR_VOTE_REG_EN
    check("upsetA_voted_lag", voted, 8'h5A);
`endif
    do_cycle(8'h5A, 8'h5A, 8'h5A, 1, 0, 1);
    check("upsetA_idle", evt_valid, 0);

    // Different lanes wrong on different bits
    do_cycle(8'h01, 8'h02, 8'h00, 1, 0, 0);
    check("multi_lane", evt_lane, 3);
    check("multi_mask", evt_mask, 8'h03);
    do_cycle(8'h00, 8'h00, 8'h00, 1, 0, 1);

    // Lane C stuck wrong, collector stalled
    apply_reset();
    do_cycle(8'h10, 8'h10, 8'h11, 1, 0, 0);
    do_cycle(8'h10, 8'h10, 8'h12, 1, 0, 0);
    do_cycle(8'h10, 8'h10, 8'h14, 1, 0, 0);
    check("stall_lane", evt_lane, 2);
    check("stall_mask", evt_mask, 8'h01);
    check("stall_ovf", evt_ovf, 1);
    check("stall_cnt", err_cnt, 3);
    do_cycle(8'h10, 8'h10, 8'h18, 1, 0, 1);
    check("b2b_valid", evt_valid, 1);
    check("b2b_mask", evt_mask, 8'h08);

    // Disabled checking: vote only
    do_cycle(8'h20, 8'h20, 8'h20, 1, 0, 1);
    do_cycle(8'hF0, 8'h0F, 8'hF0, 0, 0, 1);
    check("dis_valid", evt_valid, 0);
    check("dis_terr", tmr_err, 0);
    check("dis_cnt", err_cnt, 4);

    // Reset while an event is held
    do_cycle(8'h80, 8'h00, 8'h00, 1, 0, 0);
    check("hold_before_rst", evt_valid, 1);
    apply_reset();

    // Saturation, then clear with a concurrent error
    for (int i = 0; i < CNT_MAX + 10; i++) do_cycle(8'h00, 8'h04, 8'h00, 1, 0, 1);
    check("sat_cnt", err_cnt, CNT_MAX);
    do_cycle(8'h00, 8'h04, 8'h00, 1, 1, 1);
    check("clr_err_cnt", err_cnt, 1);
    check("clr_ovf", evt_ovf, 0);
    do_cycle(8'h00, 8'h00, 8'h00, 1, 0, 1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      base = WIDTH'($urandom);
      ra = base; rb = base; rc = base;
      kind = $urandom_range(0, 5);
      case (kind)
        1: ra ^= WIDTH'(1 << $urandom_range(0, WIDTH-1));
        2: rb ^= WIDTH'($urandom);
        3: rc ^= WIDTH'(1 << $urandom_range(0, WIDTH-1));
        4: begin ra ^= 8'h0F & WIDTH'($urandom); rc ^= 8'hF0 & WIDTH'($urandom); end
        default: ;
      endcase
      do_cycle(ra, rb, rc, $urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0,
               $urandom_range(0, 2) != 0);
      if (n == 700) apply_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
